// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default constants and PC arithmetic.
package insn_fetch_pkg;

  localparam int unsigned INSN_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/insn_fetch_fifo.sv
// Prefetch FIFO holding {pc, word} pairs; flush empties it in one cycle and
// overrides any push/pop in the same cycle.
module fetch_fifo
  import insn_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [63:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [63:0]   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok_s, push_ok_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: single-outstanding imem read FSM feeding a
// prefetch FIFO, with redirect flush and discard of an in-flight read.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       imem_addr,
  output logic              imem_read,
  input  logic [INSN_W-1:0] imem_r_line,
  input  logic              imem_ack,
  input  logic              redirect,
  input  logic [31:0]       pc_new,
  input  logic              d_ready,
  output logic [INSN_W-1:0] word,
  output logic [31:0]       word_pc,
  output logic              word_valid,
  output logic [31:0]       fetch_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   discard_addr_q, discard_addr_d;
  logic          push_s, pop_s;
  logic [63:0]   head_s;
  logic [CW-1:0] count_s, occ_s;
  logic          full_s, empty_s;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({fetch_pc_q, imem_r_line}),
    .pop       (pop_s),
    .flush     (redirect),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Occupancy after this cycle's push/pop decides whether to keep fetching.
  always_comb begin
    push_s = (state_q == ST_REQ) && imem_ack && !redirect;
    pop_s  = !empty_s && d_ready && !redirect;
    case ({push_s, pop_s})
      2'b10:   occ_s = count_s + CW'(1);
      2'b01:   occ_s = count_s - CW'(1);
      default: occ_s = count_s;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    discard_addr_d = discard_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect)               fetch_pc_d = align_pc(pc_new);
        else if (!full_s || pop_s)  state_d = ST_REQ;
        else                        state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_d = align_pc(pc_new);
          if (imem_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d        = ST_DISCARD;
            discard_addr_d = fetch_pc_q;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_INC;
          if (occ_s < DEPTH_C) state_d = ST_REQ;
          else                 state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (redirect) fetch_pc_d = align_pc(pc_new);
        else          fetch_pc_d = fetch_pc_q;
        if (imem_ack) state_d = ST_IDLE;
        else          state_d = ST_DISCARD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_REQ: begin
        imem_read = 1'b1;
        imem_addr = fetch_pc_q;
      end
      ST_DISCARD: begin
        imem_read = 1'b1;
        imem_addr = discard_addr_q;
      end
      default: begin
        imem_read = 1'b0;
        imem_addr = 32'h0000_0000;
      end
    endcase
  end

  assign word_valid = !empty_s;
  assign word       = empty_s ? NOP_WORD : head_s[31:0];
  assign word_pc    = empty_s ? 32'h0000_0000 : head_s[63:32];
  assign fetch_pc   = fetch_pc_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch with a variable-latency instruction memory
// returning addr ^ 32'hA5A50000.
module tb_insn_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XM  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_r_line;
  logic        imem_ack;
  logic        redirect;
  logic [31:0] pc_new;
  logic        d_ready;
  logic [31:0] word;
  logic [31:0] word_pc;
  logic        word_valid;
  logic [31:0] fetch_pc;

  logic [31:0] lat;
  logic        stray_ack;
  logic [31:0] wait_q;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  insn_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_read   (imem_read),
    .imem_r_line (imem_r_line),
    .imem_ack    (imem_ack),
    .redirect    (redirect),
    .pc_new      (pc_new),
    .d_ready     (d_ready),
    .word        (word),
    .word_pc     (word_pc),
    .word_valid  (word_valid),
    .fetch_pc    (fetch_pc)
  );

  // lat = extra wait cycles before ack; 0 acks in the request cycle.
  always_comb begin
    imem_ack    = stray_ack | (imem_read && (wait_q >= lat));
    imem_r_line = imem_addr ^ XM;
  end

  always @(posedge clk) begin
    if (!rst || imem_ack || !imem_read) wait_q <= 32'd0;
    else                                wait_q <= wait_q + 32'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (rst just released).
  task automatic do_reset(input logic [31:0] l, input logic dr);
    rst = 1'b0; redirect = 1'b0; pc_new = 32'd0; stray_ack = 1'b0;
    lat = l; d_ready = dr;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_read && imem_addr == a) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (word_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int acks;
    rst = 1'b0; redirect = 1'b0; pc_new = 32'd0; d_ready = 1'b0;
    lat = 32'd0; stray_ack = 1'b0;

    // Reset state and zero-wait streaming
    d_ready = 1'b1;
    tick(); tick();
    check_eq("rst_read", {31'd0, imem_read}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);
    check_eq("rst_valid", {31'd0, word_valid}, 32'd0);
    check_eq("rst_word", word, NOP);
    check_eq("rst_word_pc", word_pc, 32'd0);
    check_eq("rst_fetch_pc", fetch_pc, 32'd0);
    rst = 1'b1;
    check_eq("c0_read", {31'd0, imem_read}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("stream_read", {31'd0, imem_read}, 32'd1);
      check_eq("stream_addr", imem_addr, 32'(4 * (k - 1)));
      if (k == 1) begin
        check_eq("c1_valid", {31'd0, word_valid}, 32'd0);
      end else begin
        check_eq("stream_valid", {31'd0, word_valid}, 32'd1);
        check_eq("stream_pc", word_pc, 32'(4 * (k - 2)));
        check_eq("stream_word", word, 32'(4 * (k - 2)) ^ XM);
      end
    end

    // Fill with decoder stalled, then restart on first pop
    do_reset(32'd0, 1'b0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_ack) acks++;
      tick();
    end
    check_eq("full_acks", 32'(acks), 32'd4);
    check_eq("full_read", {31'd0, imem_read}, 32'd0);
    check_eq("full_fetch_pc", fetch_pc, 32'd16);
    check_eq("full_head_pc", word_pc, 32'd0);
    d_ready = 1'b1;
    tick();
    check_eq("restart_read", {31'd0, imem_read}, 32'd1);
    check_eq("restart_addr", imem_addr, 32'd16);
    check_eq("restart_head_pc", word_pc, 32'd4);

    // Redirect while a slow read to 8 is outstanding
    do_reset(32'd2, 1'b1);
    wait_req(32'd8, "wait_req8");
    tick();
    redirect = 1'b1; pc_new = 32'h0000_0100;
    check_eq("disc_addr_a", imem_addr, 32'd8);
    check_eq("disc_noack", {31'd0, imem_ack}, 32'd0);
    tick();
    redirect = 1'b0;
    check_eq("disc_read", {31'd0, imem_read}, 32'd1);
    check_eq("disc_addr_b", imem_addr, 32'd8);
    check_eq("disc_fetch_pc", fetch_pc, 32'h0000_0100);
    check_eq("disc_valid", {31'd0, word_valid}, 32'd0);
    wait_req(32'h0000_0100, "wait_req100");
    wait_valid("wait_valid100");
    check_eq("disc_first_pc", word_pc, 32'h0000_0100);
    check_eq("disc_first_word", word, 32'h0000_0100 ^ XM);

    // Redirect coinciding with ack and pop; unaligned target
    do_reset(32'd0, 1'b1);
    tick(); tick(); tick();
    redirect = 1'b1; pc_new = 32'h0000_0203;
    check_eq("rdak_ack", {31'd0, imem_ack}, 32'd1);
    check_eq("rdak_head_pc", word_pc, 32'd4);
    tick();
    redirect = 1'b0;
    check_eq("rdak_valid", {31'd0, word_valid}, 32'd0);
    check_eq("rdak_word_pc", word_pc, 32'd0);
    check_eq("rdak_fetch_pc", fetch_pc, 32'h0000_0200);
    tick();
    check_eq("rdak_req", imem_addr, 32'h0000_0200);
    tick();
    check_eq("rdak_first_valid", {31'd0, word_valid}, 32'd1);
    check_eq("rdak_first_pc", word_pc, 32'h0000_0200);

    // PC wrap at top of address space
    do_reset(32'd0, 1'b1);
    redirect = 1'b1; pc_new = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    check_eq("wrap_fetch_pc", fetch_pc, 32'hFFFF_FFF8);
    tick();
    check_eq("wrap_req0", imem_addr, 32'hFFFF_FFF8);
    tick();
    check_eq("wrap_req1", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_req2", imem_addr, 32'h0000_0000);
    check_eq("wrap_pc1", word_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_pc2", word_pc, 32'h0000_0000);
    check_eq("wrap_word2", word, XM);

    // Reset during a pending read, stray ack afterwards
    do_reset(32'd2, 1'b0);
    wait_req(32'd4, "wait_req4");
    check_eq("mid_valid_pre", {31'd0, word_valid}, 32'd1);
    tick();
    rst = 1'b0;
    check_eq("mid_pending", imem_addr, 32'd4);
    tick();
    rst = 1'b1; stray_ack = 1'b1;
    check_eq("mid_read", {31'd0, imem_read}, 32'd0);
    check_eq("mid_addr", imem_addr, 32'd0);
    check_eq("mid_valid", {31'd0, word_valid}, 32'd0);
    check_eq("mid_word", word, NOP);
    check_eq("mid_word_pc", word_pc, 32'd0);
    check_eq("mid_fetch_pc", fetch_pc, 32'd0);
    tick();
    stray_ack = 1'b0;
    check_eq("mid_resume_read", {31'd0, imem_read}, 32'd1);
    check_eq("mid_resume_addr", imem_addr, 32'd0);
    check_eq("mid_stray_nopush", {31'd0, word_valid}, 32'd0);
    d_ready = 1'b1;
    wait_valid("wait_valid_mid");
    check_eq("mid_first_pc", word_pc, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
